ahb_req_arbiter: RTL

AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

---
 rtl/ahb_req_arbiter_pkg.sv | 17 +
 rtl/ahb_req_arbiter_if.sv | 41 ++++
 rtl/ahb_rr_arb2.sv | 21 ++
 rtl/ahb_req_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ahb_req_arbiter_pkg.sv
// Shared definitions for the two-requester AHB command arbiter:
// FSM encoding, datapath widths and the default timeout.
package ahb_req_arbiter_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int CNT_W           = 9;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// Requester command/response channels plus the single-transfer master
// datapath handshake. The arbiter sits on the slave modport.
interface ahb_req_arbiter_if;
    import ahb_req_arbiter_pkg::*;

    logic [1:0]        rq_valid;
    logic [1:0]        rq_ready;
    logic [1:0]        rq_write;
    logic [ADDR_W-1:0] rq_addr0;
    logic [ADDR_W-1:0] rq_addr1;
    logic [DATA_W-1:0] rq_wdata0;
    logic [DATA_W-1:0] rq_wdata1;

    logic [1:0]        rs_valid;
    logic [1:0]        rs_ready;
    logic [DATA_W-1:0] rs_rdata;
    logic              rs_err;

    logic              m_valid;
    logic              m_ready;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_done;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  rq_valid, rq_write, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1,
        input  rs_ready, m_ready, m_done, m_rdata,
        output rq_ready, rs_valid, rs_rdata, rs_err,
        output m_valid, m_write, m_addr, m_wdata
    );

    modport master (
        output rq_valid, rq_write, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1,
        output rs_ready, m_ready, m_done, m_rdata,
        input  rq_ready, rs_valid, rs_rdata, rs_err,
        input  m_valid, m_write, m_addr, m_wdata
    );

endinterface

// File: rtl/ahb_rr_arb2.sv
// Combinational two-way round-robin grant: on a tie, the requester that
// was not served last wins.
module ahb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Two-requester arbiter feeding one AHB master datapath: one command in
// flight, round-robin grant, timeout-forced error completion.
module ahb_req_arbiter
    import ahb_req_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_req_arbiter_if.slave  bus
);

    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int TO_LAST_I = (TIMEOUT_CYC - 1 > CNT_MAX) ? CNT_MAX : TIMEOUT_CYC - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    arb_state_e        state_q, state_d;
    logic              gnt_idx_q, gnt_idx_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] rs_rdata_q, rs_rdata_d;
    logic              rs_err_q, rs_err_d;
    logic [1:0]        gnt;
    logic              timeout_hit;

    ahb_rr_arb2 u_rr_arb2 (
        .req  (bus.rq_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    // Timeout is decided in the last ISSUE/WAIT cycle, so the error response
    // appears exactly TIMEOUT_CYC cycles after the accept cycle.
    assign cnt_inc     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc >= TO_LAST);

    always_comb begin
        state_d      = state_q;
        gnt_idx_d    = gnt_idx_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        m_write_d    = m_write_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        rs_rdata_d   = rs_rdata_q;
        rs_err_d     = rs_err_q;
        bus.rq_ready = 2'b00;
        bus.rs_valid = 2'b00;
        bus.m_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus.rq_valid) begin
                    bus.rq_ready = gnt;
                    gnt_idx_d    = gnt[1];
                    m_write_d    = gnt[1] ? bus.rq_write[1] : bus.rq_write[0];
                    m_addr_d     = gnt[1] ? bus.rq_addr1    : bus.rq_addr0;
                    m_wdata_d    = gnt[1] ? bus.rq_wdata1   : bus.rq_wdata0;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                bus.m_valid = 1'b1;
                cnt_d       = cnt_inc;
                if (timeout_hit) begin
                    rs_err_d   = 1'b1;
                    rs_rdata_d = '0;
                    state_d    = RESP;
                end else if (bus.m_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // A completion arriving on the timeout cycle still counts as success.
                if (bus.m_done) begin
                    rs_rdata_d = m_write_q ? '0 : bus.m_rdata;
                    rs_err_d   = 1'b0;
                    state_d    = RESP;
                end else if (timeout_hit) begin
                    rs_err_d   = 1'b1;
                    rs_rdata_d = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                bus.rs_valid = gnt_idx_q ? 2'b10 : 2'b01;
                if (bus.rs_ready[gnt_idx_q]) begin
                    last_d  = gnt_idx_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            gnt_idx_q  <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            m_write_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            rs_rdata_q <= '0;
            rs_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            m_write_q  <= m_write_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            rs_rdata_q <= rs_rdata_d;
            rs_err_q   <= rs_err_d;
        end
    end

    assign bus.m_write  = m_write_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.rs_rdata = rs_rdata_q;
    assign bus.rs_err   = rs_err_q;

endmodule
